// File: rtl/regs_param.sv
// picoMIPS register file: two combinational read ports, one synchronous write port,
// switches memory-mapped at addresses 1/2, GPR[OUTREG] mirrored to out. Option: WRITE_BYPASS_EN.
module regs_param #(
  parameter int N      = 8,
  parameter int NREGS  = 4,
  parameter int AW     = 3,
  parameter int OUTREG = 1
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          w,
  input  logic [N-1:0]  Wdata,
  input  logic [AW-1:0] Raddr1,
  input  logic [AW-1:0] Raddr2,
  input  logic [N:0]    SW,
  output logic [N-1:0]  Rdata1,
  output logic [N-1:0]  Rdata2,
  output logic [N-1:0]  out,
  output logic          werr
);

  localparam int GPR_BASE = 3;

  logic [N-1:0]     r_gpr [NREGS];
  logic [N:0]       r_s1;
  logic [N:0]       r_s2;
  logic [N-1:0]     r_out;
  logic             r_werr;
  logic [NREGS-1:0] w_we;
  logic             w_wr_hit;
  logic [N-1:0]     w_rdata1;
  logic [N-1:0]     w_rdata2;

  // One-hot write decode; only GPR addresses can be hit, so w_wr_hit=0 flags an illegal write.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
      assign w_we[gi] = w && (Raddr2 == AW'(GPR_BASE + gi));
    end
  endgenerate

  assign w_wr_hit = |w_we;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_out  <= '0;
      r_werr <= 1'b0;
    end else begin
      r_s1   <= SW;
      r_s2   <= r_s1;
      r_out  <= r_gpr[OUTREG];
      r_werr <= w && !w_wr_hit;
      for (int i = 0; i < NREGS; i++) begin
        if (w_we[i]) r_gpr[i] <= Wdata;
      end
    end
  end

  // The switch flag is only visible through port 1.
  always_comb begin
    w_rdata1 = '0;
    if (Raddr1 == AW'(1)) w_rdata1 = {{(N-1){1'b0}}, r_s2[N]};
    if (Raddr1 == AW'(2)) w_rdata1 = r_s2[N-1:0];
    for (int i = 0; i < NREGS; i++) begin
      if (Raddr1 == AW'(GPR_BASE + i)) w_rdata1 = r_gpr[i];
    end
`ifdef WRITE_BYPASS_EN
    if (w_wr_hit && (Raddr1 == Raddr2)) w_rdata1 = Wdata;
`endif
  end

  always_comb begin
    w_rdata2 = '0;
    if (Raddr2 == AW'(2)) w_rdata2 = r_s2[N-1:0];
    for (int i = 0; i < NREGS; i++) begin
      if (Raddr2 == AW'(GPR_BASE + i)) w_rdata2 = r_gpr[i];
    end
`ifdef WRITE_BYPASS_EN
    if (w_wr_hit) w_rdata2 = Wdata;
`endif
  end

  assign Rdata1 = w_rdata1;
  assign Rdata2 = w_rdata2;
  assign out    = r_out;
  assign werr   = r_werr;

endmodule

// File: tb/tb_regs_param.sv
// Scoreboard bench for regs_param: stimulus queues expectations, a negedge monitor checks them.
module tb_regs_param;

  logic       clk = 1'b0;
  logic       nReset;
  logic       w;
  logic [7:0] Wdata;
  logic [2:0] Raddr1;
  logic [2:0] Raddr2;
  logic [8:0] SW;
  logic [7:0] Rdata1;
  logic [7:0] Rdata2;
  logic [7:0] out;
  logic       werr;

  regs_param #(.N(8), .NREGS(4), .AW(3), .OUTREG(1)) dut (
    .clk(clk), .nReset(nReset), .w(w), .Wdata(Wdata),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .SW(SW),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .out(out), .werr(werr)
  );

  always #5 clk = ~clk;

  // sel: 0=Rdata1 1=Rdata2 2=out 3=werr
  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input int sel, input logic [7:0] exp, input string name);
    chk_t c;
    c.sel = sel; c.exp = exp; c.name = name;
    sb_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
    Raddr2 = addr; Wdata = data; w = 1'b1;
    tick();
    w = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the DUT state at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      chk_t c;
      logic [7:0] act;
      c = sb_q.pop_front();
      case (c.sel)
        0:       act = Rdata1;
        1:       act = Rdata2;
        2:       act = out;
        default: act = {7'b0, werr};
      endcase
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %02h expected %02h", c.name, act, c.exp);
      end else begin
        $display("[TB] ok %s = %02h", c.name, act);
      end
    end
  end

  initial begin
    nReset = 1'b0; w = 1'b0; Wdata = '0; Raddr1 = '0; Raddr2 = '0; SW = '0;
    tick();
    Raddr1 = 3'd3;
    expect_val(2, 8'h00, "rst_out");
    expect_val(3, 8'h00, "rst_werr");
    expect_val(0, 8'h00, "rst_rd1_gpr0");
    tick();
    nReset = 1'b1;
    tick();

    // Basic write/read
    do_write(3'd3, 8'hA5);
    do_write(3'd6, 8'h3C);
    Raddr1 = 3'd3; Raddr2 = 3'd6;
    expect_val(0, 8'hA5, "wr_rd1_a3");
    expect_val(1, 8'h3C, "wr_rd2_a6");
    expect_val(2, 8'h00, "wr_out");
    expect_val(3, 8'h00, "wr_werr");
    tick();

    // Output lag through the registered mirror
    Raddr2 = 3'd4; Wdata = 8'h77; w = 1'b1;
    expect_val(2, 8'h00, "lag_pre");
    tick();
    w = 1'b0; Raddr1 = 3'd4;
    expect_val(2, 8'h00, "lag_k");
    expect_val(0, 8'h77, "lag_gpr");
    tick();
    expect_val(2, 8'h77, "lag_k1");
    tick();

    // Illegal writes: switch data address and unmapped address
    do_write(3'd2, 8'hFF);
    Raddr1 = 3'd2; Raddr2 = 3'd6;
    expect_val(3, 8'h01, "ill2_werr");
    expect_val(0, 8'h00, "ill2_rd_a2");
    expect_val(1, 8'h3C, "ill2_rd_a6");
    tick();
    Raddr1 = 3'd3;
    expect_val(3, 8'h00, "ill2_werr_end");
    expect_val(0, 8'hA5, "ill2_rd_a3");
    do_write(3'd7, 8'hFF);
    Raddr2 = 3'd7;
    expect_val(3, 8'h01, "ill7_werr");
    expect_val(1, 8'h00, "ill7_rd2_a7");
    tick();
    Raddr1 = 3'd4;
    expect_val(3, 8'h00, "ill7_werr_end");
    expect_val(0, 8'h77, "ill7_rd_a4");
    tick();

    // Switch synchroniser: change just after edge k
    SW = 9'h1C3; Raddr1 = 3'd1; Raddr2 = 3'd2;
    expect_val(0, 8'h00, "sw_k_flag");
    tick();
    expect_val(0, 8'h00, "sw_k1_flag");
    expect_val(1, 8'h00, "sw_k1_data");
    tick();
    expect_val(0, 8'h01, "sw_k2_flag");
    expect_val(1, 8'hC3, "sw_k2_data");
    tick();
    Raddr1 = 3'd2; Raddr2 = 3'd1;
    expect_val(0, 8'hC3, "sw_rd1_data");
    expect_val(1, 8'h00, "sw_rd2_flag_hidden");
    tick();

    // Same-cycle read/write of one GPR
    do_write(3'd5, 8'h11);
    Raddr1 = 3'd5; Raddr2 = 3'd5; Wdata = 8'h99; w = 1'b1;
`ifdef WRITE_BYPASS_EN
    expect_val(0, 8'h99, "byp_rd1");
    expect_val(1, 8'h99, "byp_rd2");
`else
    expect_val(0, 8'h11, "byp_rd1");
    expect_val(1, 8'h11, "byp_rd2");
`endif
    tick();
    w = 1'b0;
    expect_val(0, 8'h99, "byp_after");
    tick();

    // Mid-run reset with gpr[1]=5A; a write during reset is lost
    do_write(3'd4, 8'h5A);
    tick();
    Raddr1 = 3'd4;
    expect_val(2, 8'h5A, "pre_rst_out");
    tick();
    nReset = 1'b0; Raddr2 = 3'd3; Wdata = 8'hEE; w = 1'b1;
    expect_val(2, 8'h00, "mid_rst_out");
    expect_val(0, 8'h00, "mid_rst_rd1");
    expect_val(3, 8'h00, "mid_rst_werr");
    tick();
    nReset = 1'b1; w = 1'b0; Raddr1 = 3'd3;
    expect_val(0, 8'h00, "rst_write_lost");
    do_write(3'd3, 8'h42);
    expect_val(0, 8'h42, "post_rst_write");
    tick();
    tick();

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left unexamined, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
